// File: rtl/led_pkg.sv
// led_pkg: mode encodings and width helpers shared by the LED pattern generator
package led_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF    = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ON     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_STROBE = 3'd2;
  localparam logic [MODE_W-1:0] MODE_PWM    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 3'd4;

  // Channel-index width; a single channel still needs a 1-bit index port
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: config write bus from control logic to the LED generator
interface led_pattern_gen_if
  import led_pkg::*;
#(
  parameter int CH_W  = 1,
  parameter int CNT_W = 32
);

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [MODE_W-1:0] cfg_mode;
  logic [CNT_W-1:0]  cfg_thr;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_thr);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_thr);

endinterface

// File: rtl/led_channel.sv
// led_channel: one LED channel holding its mode/threshold and registered drive
module led_channel
  import led_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              wrap_evt_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [CNT_W-1:0]  thr_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic              led_o
);

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic              blink_q, blink_d;
  logic              led_q, led_d;

  // Next state: a write overrides everything (including a same-cycle wrap toggle)
  always_comb begin
    mode_d  = we_i ? mode_i : mode_q;
    thr_d   = we_i ? thr_i : thr_q;
    blink_d = we_i ? 1'b0 : (wrap_evt_i && mode_q == MODE_BLINK) ? ~blink_q : blink_q;
    led_d   = (mode_q == MODE_ON)     ? 1'b1 :
              (mode_q == MODE_STROBE) ? (cnt_i == thr_i_eff(thr_q)) :
              (mode_q == MODE_PWM)    ? (cnt_i < thr_q) :
              (mode_q == MODE_BLINK)  ? blink_q : 1'b0;
  end

  // Channel registers; reserved modes fall through to OFF above
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_OFF;
      thr_q   <= '0;
      blink_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  function automatic logic [CNT_W-1:0] thr_i_eff(input logic [CNT_W-1:0] t);
    return t;
  endfunction

  assign led_o = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: shared prescaler/period counter driving NUM_CH mode-selectable LEDs
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  parameter int PERIOD   = 200,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  led_pattern_gen_if.slave  cfg,
  output logic [NUM_CH-1:0] led,
  output logic              wrap
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, tick, wrap_evt;

  // Tick generation and counter next state; everything holds while disabled
  always_comb begin
    tick      = enable && pre_cnt_q == PRE_W'(PRESCALE - 1);
    wrap_evt  = tick && cnt_q == CNT_W'(PERIOD);
    pre_cnt_d = !enable ? pre_cnt_q : tick ? '0 : pre_cnt_q + 1'b1;
    cnt_d     = !tick ? cnt_q : wrap_evt ? '0 : cnt_q + 1'b1;
  end

  // Prescaler, period counter and the registered wrap pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_evt;
    end
  end

  assign wrap = wrap_q;

  // Out-of-range channel indices match no channel, so such writes are dropped
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    led_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .we_i       (cfg.cfg_we && cfg.cfg_ch == CH_W'(c)),
      .wrap_evt_i (wrap_evt),
      .mode_i     (cfg.cfg_mode),
      .thr_i      (cfg.cfg_thr),
      .cnt_i      (cnt_q),
      .led_o      (led[c])
    );
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised multi-channel LED driver. It is the next generation of the single fixed-strobe LED blinker.
- One shared prescaler and period counter drive NUM_CH independent channels.
- Each channel runs in a runtime-selectable mode: off, on, strobe, PWM or blink.
- Sits at board top level between the control logic (config writes) and the LED pins.
- Default configuration, with ch0 in STROBE at threshold 100, reproduces the legacy 1-cycle-in-201 strobe.

Parameters:
NUM_CH, 2, number of LED channels (>=1)
CNT_W, 32, width of the period counter and the thresholds
PERIOD, 200, counter terminal value; counter runs 0..PERIOD, so the period is PERIOD+1 ticks (>=1)
PRESCALE, 1, clocks per counter tick (>=1)
CH_W, derived, cfg_ch width = (NUM_CH>1) ? $clog2(NUM_CH) : 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
enable  in  1  1 = counters advance; 0 = counters freeze
cfg_we  in  1  config write strobe, single cycle
cfg_ch  in  CH_W  channel index for the write
cfg_mode  in  3  mode for the write (encodings in led_pkg)
cfg_thr  in  CNT_W  threshold for the write
led  out  NUM_CH  registered LED drive, one bit per channel
wrap  out  1  registered 1-cycle pulse, issued the cycle after the counter wraps

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - pre_cnt=0, cnt=0, led=0, wrap=0.
  - Every channel: mode=OFF, thr=0, blink_q=0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 while enable=1.
  - tick = enable && pre_cnt==PRESCALE-1.
  - PRESCALE=1 gives tick=enable.
- Counter:
  - On tick: cnt <= (cnt==PERIOD) ? 0 : cnt+1.
  - wrap_evt = tick && cnt==PERIOD; the wrap output is wrap_evt registered.
  - cnt never exceeds PERIOD.
- enable=0: pre_cnt and cnt hold, no wrap, led keeps being evaluated from the frozen values.
- Mode encodings: 0 OFF, 1 ON, 2 STROBE, 3 PWM, 4 BLINK. Values 5-7 are reserved and behave as OFF.
- Per-channel next-state led_d:
  - OFF: 0.
  - ON: 1.
  - STROBE: cnt==thr.
  - PWM: cnt<thr.
  - BLINK: blink_q.
- blink_q toggles on every wrap_evt while mode==BLINK.
- Latency: led <= led_d every clock, so led lags cnt by exactly 1 cycle.
- Config write:
  - On cfg_we with cfg_ch<NUM_CH: mode and thr are written at that edge.
  - led reflects the new setting on the following edge, i.e. 2 cycles from the cfg_we cycle.
  - Writing BLINK clears blink_q to 0.
  - cfg_ch>=NUM_CH: the write is ignored and no channel changes.
- Boundary conditions:
  - STROBE with thr>PERIOD never fires.
  - PWM with thr=0 is always 0.
  - PWM with thr>PERIOD is always 1.
  - A config write in the same cycle as wrap_evt: the write wins for that channel, and a BLINK write leaves blink_q=0.
  - Reset mid-operation clears everything immediately. Counting resumes from 0 on the first tick after release.

Decomposition:
- led_pkg holds:
  - mode localparams (MODE_OFF..MODE_BLINK) and the mode width of 3;
  - the helper function for CH_W.
- Sub-module led_channel holds the mode/thr/blink_q registers and the led_d logic plus output flop.
  - Inputs: cnt, wrap_evt, write-enable (decoded in the top).
  - Instantiated NUM_CH times via generate.
- The top holds the prescaler, period counter, wrap flop and address decode.

Test Plan:
1. Reset held 5 cycles, then released, all channels OFF, 500 cycles -> led==0 throughout; wrap pulses at cycles 201 and 402 after release (period 201).
2. ch0 STROBE thr=100, PRESCALE=1 -> led[0]=1 for exactly 1 cycle per 201, one cycle after cnt==100; thr=250 -> led[0] never 1.
3. ch1 PWM thr=50 -> led[1] high 50 of every 201 cycles; thr=0 -> constant 0; thr=300 -> constant 1.
4. ch0 BLINK, PRESCALE=4 -> counter period 804 clocks; led[0] toggles once every 804 clocks; starts at 0 after the write.
5. enable=0 at cnt=37 for 20 cycles -> cnt stays 37, no wrap, led steady. Then rst=0 asserted between clock edges -> led=0 and cnt=0 immediately; resumes from 0 after release.
6. NUM_CH=3: write cfg_ch=3, mode ON -> no led change. Write cfg_ch=2, mode ON at cycle N -> led[2]=1 at cycle N+2.
